nios_system_key_edge_pio: RTL and testbench

//  Avalon-MM slave input PIO: the read-side counterpart of the HEX output PIOs. It samples

---
 rtl/nios_system_key_edge_pio_pkg.sv | 31 +++
 rtl/nios_system_key_edge_pio_sync.sv | 30 +++
 rtl/nios_system_key_edge_pio.sv | 101 ++++++++++
 tb/tb_nios_system_key_edge_pio.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_key_edge_pio_pkg.sv
// Shared definitions for the PIO family: register word addresses and the
// edge-type encodings used by input PIOs.
package nios_system_key_edge_pio_pkg;

  // Register word addresses on the 2-bit Avalon address bus
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Edge-type encodings for the EDGE_TYPE parameter
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Per-bit edge events between the previous and current synchronised values
  function automatic logic [31:0] edge_event(input int edge_type,
                                             input logic [31:0] cur,
                                             input logic [31:0] prev);
    logic [31:0] rise;
    logic [31:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_type)
      EDGE_RISING:  return rise;
      EDGE_FALLING: return fall;
      default:      return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/nios_system_key_edge_pio_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous inputs.
module pio_bit_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift the raw inputs through the synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every chain flop is reset so the first post-reset sample is a
      // known 0 rather than X; the arming counter relies on that.
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, giving a true shift register.
      stage_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios_system_key_edge_pio.sv
// Avalon-MM input PIO with per-bit edge capture and a maskable level IRQ.
module nios_system_key_edge_pio
  import nios_system_key_edge_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_FALLING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Edges are ignored until the synchroniser and prev flops hold real samples
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [ARM_W-1:0] arm_cnt_q;

  logic             armed;
  logic             wr_en;
  logic [31:0]      ev_all;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] irqmask_next;
  logic [WIDTH-1:0] edgecap_next;
  logic [31:0]      rd_mux;

  pio_bit_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (sync_q)
  );

  assign armed  = (arm_cnt_q == ARM_W'(ARM_CYCLES));
  assign wr_en  = chipselect && !write_n;
  assign ev_all = edge_event(EDGE_TYPE, 32'(sync_q), 32'(prev_q));

  // Upper bus and event bits carry nothing when WIDTH < 32
  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_bits;
      assign unused_bits = ^{writedata[31:WIDTH], ev_all[31:WIDTH]};
    end
  endgenerate

  // Next-state for mask and capture registers, plus the read mux
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    ev           = armed ? ev_all[WIDTH-1:0] : '0;
    irqmask_next = irqmask_q;
    edgecap_next = edgecap_q;
    rd_mux       = '0;

    if (wr_en && address == ADDR_IRQMASK) irqmask_next = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) edgecap_next = edgecap_q & ~writedata[WIDTH-1:0];
    // A new event overrides a same-cycle clear of that bit
    edgecap_next = edgecap_next | ev;

    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap_q;
      default:      rd_mux            = '0;
    endcase
  end

  // Arming counter, edge history, register file, read data and irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= '0;
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
      prev_q    <= sync_q;
      irqmask_q <= irqmask_next;
      edgecap_q <= edgecap_next;
      if (chipselect) readdata <= rd_mux;
      irq       <= |(edgecap_next & irqmask_next);
    end
  end

endmodule

// File: tb/tb_nios_system_key_edge_pio.sv
// Self-checking bench for nios_system_key_edge_pio (WIDTH=4, falling edge, 2 sync stages).
module tb_nios_system_key_edge_pio;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model: history of pin samples taken at each clock since reset release
  logic [3:0]  samp [$];
  int          m_k;
  logic [3:0]  m_ec;
  logic [3:0]  m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  nios_system_key_edge_pio #(
    .WIDTH       (4),
    .EDGE_TYPE   (1),
    .SYNC_STAGES (S)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Synchronised pin value visible after clock k: the pin sampled S-1 clocks earlier
  function automatic logic [3:0] sync_after(int k);
    if (k - S + 1 < 1) return 4'h0;
    return samp[k - S];
  endfunction

  task automatic model_reset();
    samp.delete();
    m_k    = 0;
    m_ec   = '0;
    m_mask = '0;
    m_rd   = '0;
    m_irq  = 1'b0;
  endtask

  // Advance the model by one clock using the bus and pin values just sampled
  task automatic model_edge();
    logic [3:0] cur;
    logic [3:0] old;
    logic [3:0] fell;
    m_k++;
    samp.push_back(in_port);
    cur  = sync_after(m_k - 1);
    old  = sync_after(m_k - 2);
    fell = (m_k >= S + 2) ? (old & ~cur) : 4'h0;
    if (chipselect) begin
      case (address)
        2'd0:    m_rd = {28'h0, cur};
        2'd2:    m_rd = {28'h0, m_mask};
        2'd3:    m_rd = {28'h0, m_ec};
        default: m_rd = 32'h0;
      endcase
    end
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
    if (chipselect && !write_n && address == 2'd3) m_ec = m_ec & ~writedata[3:0];
    m_ec  = m_ec | fell;
    m_irq = |(m_ec & m_mask);
  endtask

  // One bus cycle: drive, clock, update model, settle
  task automatic cycle(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 2'd0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_port = 4'hF;
    do_reset();
    checks++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b readdata=%h, want 0 and 0", irq, readdata);
    end
    cycle(1'b1, 1'b0, 2'd2, 32'hF);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL arm_irq cycle %0d: irq=%b, want 0", i, irq);
      end
    end
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL arm_edgecap: got %h, want 00000000", readdata);
    end
  endtask

  task automatic test_falling_irq();
    cycle(1'b1, 1'b0, 2'd2, 32'h2);
    in_port = 4'hD;
    idle(2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL early_irq: irq=%b, want 0", irq);
    end
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL edgecap_pin2: got %h, want 00000000", readdata);
    end
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    checks++;
    if (readdata !== 32'h2) begin
      errors++;
      $display("FAIL edgecap_pin3: got %h, want 00000002", readdata);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_pin4: irq=%b, want 1", irq);
    end
    cycle(1'b1, 1'b0, 2'd3, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b, want 0", irq);
    end
  endtask

  task automatic test_masked();
    cycle(1'b1, 1'b0, 2'd2, 32'h0);
    in_port = 4'hC;
    idle(4);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_irq: irq=%b, want 0", irq);
    end
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    checks++;
    if (readdata !== 32'h1) begin
      errors++;
      $display("FAIL masked_edgecap: got %h, want 00000001", readdata);
    end
    cycle(1'b1, 1'b0, 2'd2, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL unmask_irq: irq=%b, want 1", irq);
    end
    cycle(1'b1, 1'b0, 2'd3, 32'hF);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_clear: irq=%b, want 0", irq);
    end
  endtask

  task automatic test_set_wins();
    in_port = 4'h4;
    idle(2);
    cycle(1'b1, 1'b0, 2'd3, 32'h8);
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    checks++;
    if (readdata !== 32'h8) begin
      errors++;
      $display("FAIL set_wins: got %h, want 00000008", readdata);
    end
    cycle(1'b1, 1'b0, 2'd3, 32'hF);
  endtask

  task automatic test_readback();
    in_port = 4'hA;
    idle(4);
    cycle(1'b1, 1'b1, 2'd0, 32'h0);
    checks++;
    if (readdata !== 32'h0000000A) begin
      errors++;
      $display("FAIL read_data: got %h, want 0000000a", readdata);
    end
    cycle(1'b1, 1'b1, 2'd1, 32'h0);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL read_rsvd: got %h, want 00000000", readdata);
    end
    cycle(1'b1, 1'b0, 2'd2, 32'hFFFF_FFF5);
    cycle(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 2'd2, 32'h0);
    checks++;
    if (readdata !== 32'h5) begin
      errors++;
      $display("FAIL read_mask: got %h, want 00000005", readdata);
    end
    idle(2);
    checks++;
    if (readdata !== 32'h5) begin
      errors++;
      $display("FAIL read_hold: got %h, want 00000005", readdata);
    end
  endtask

  task automatic test_reset_mid();
    in_port = 4'hF;
    idle(4);
    cycle(1'b1, 1'b0, 2'd3, 32'hF);
    cycle(1'b1, 1'b0, 2'd2, 32'hF);
    in_port = 4'h0;
    idle(4);
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    checks++;
    if (readdata !== 32'hF || irq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: readdata=%h irq=%b, want 0000000f and 1", readdata, irq);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: readdata=%h irq=%b, want 00000000 and 0", readdata, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 1'b1, 2'd2, 32'h0);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL mask_after_reset: got %h, want 00000000", readdata);
    end
    cycle(1'b1, 1'b0, 2'd2, 32'hF);
    idle(8);
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rearm: readdata=%h irq=%b, want 00000000 and 0", readdata, irq);
    end
  endtask

  task automatic test_random();
    in_port = 4'($urandom);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int unsigned op;
      if ($urandom_range(3) == 0) in_port = 4'($urandom);
      op = $urandom_range(3);
      case (op)
        0:       cycle(1'b0, 1'b1, 2'($urandom), $urandom);
        1, 3:    cycle(1'b1, 1'b1, 2'($urandom), $urandom);
        default: cycle(1'b1, 1'b0, 2'($urandom), $urandom);
      endcase
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL rand_irq step %0d: got %b, want %b", i, irq, m_irq);
      end
      checks++;
      if (readdata !== m_rd) begin
        errors++;
        $display("FAIL rand_readdata step %0d: got %h, want %h", i, readdata, m_rd);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
    in_port    = 4'hF;
    model_reset();
    test_reset();
    test_falling_irq();
    test_masked();
    test_set_wins();
    test_readback();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
